// File: rtl/lbp_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lbp_pkg : shared FSM encoding and neighbour bit positions for the LBP engine
// Revision : 1.0
// ---------------------------------------------------------------------------
package lbp_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_FLUSH = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // Bit position of each neighbour in the LBP code
  localparam int B_TL = 0;
  localparam int B_T  = 1;
  localparam int B_TR = 2;
  localparam int B_L  = 3;
  localparam int B_R  = 4;
  localparam int B_BL = 5;
  localparam int B_B  = 6;
  localparam int B_BR = 7;

endpackage
`default_nettype wire

// File: rtl/lbp_line_buf.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lbp_line_buf : one image row of delay; read-before-write at a circular pointer
// Revision     : 1.0
// ---------------------------------------------------------------------------
module lbp_line_buf #(
  parameter int DEPTH = 128,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (shift_en) begin
      ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Contents are don't-care after reset: the first two rows only feed border centres
  always_ff @(posedge clk) begin
    if (shift_en) begin
      mem_q[ptr_q] <= wr_data;
    end
  end

  assign rd_data = mem_q[ptr_q];

endmodule
`default_nettype wire

// File: rtl/lbp_stream_engine.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lbp_stream_engine : raster-order streaming 3x3 LBP with line buffers
// Revision          : 1.0
// ---------------------------------------------------------------------------
module lbp_stream_engine
  import lbp_pkg::*;
#(
  parameter int IMG_W        = 128,
  parameter int IMG_H        = 128,
  parameter int PIX_W        = 8,
  parameter int ADDR_W       = 14,
  parameter int THRESH       = 0,
  parameter int WRITE_BORDER = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gray_ready,
  output logic              gray_req,
  output logic [ADDR_W-1:0] gray_addr,
  input  logic [PIX_W-1:0]  gray_data,
  output logic              lbp_valid,
  output logic [ADDR_W-1:0] lbp_addr,
  output logic [7:0]        lbp_data,
  output logic              finish
);

  localparam int NPIX  = IMG_W * IMG_H;
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int FL_W  = $clog2(IMG_W + 2);

  localparam logic [ADDR_W-1:0] K_LAST      = ADDR_W'(NPIX - 1);
  localparam logic [ADDR_W-1:0] K_FIRST_OUT = ADDR_W'(IMG_W + 1);
  localparam logic [COL_W-1:0]  COL_LAST    = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST    = ROW_W'(IMG_H - 1);
  localparam logic [FL_W-1:0]   FL_LAST     = FL_W'(IMG_W);
  localparam logic [PIX_W:0]    THR_EXT     = (PIX_W + 1)'(THRESH);

  state_t state_q, state_d;
  logic [ADDR_W-1:0] k_q, k_d;
  logic [FL_W-1:0]   fl_q, fl_d;

  logic [ADDR_W-1:0] cen_addr_q, cen_addr_d;
  logic [COL_W-1:0]  cen_col_q, cen_col_d;
  logic [ROW_W-1:0]  cen_row_q, cen_row_d;

  logic              lbp_valid_q, lbp_valid_d;
  logic [ADDR_W-1:0] lbp_addr_q, lbp_addr_d;
  logic [7:0]        lbp_data_q, lbp_data_d;
  logic              finish_q, finish_d;

  logic [PIX_W-1:0] win_q [3][2];
  logic [PIX_W-1:0] win_d [3][2];

  logic             rd_accept;
  logic [PIX_W-1:0] top_new;
  logic [PIX_W-1:0] mid_new;
  logic [PIX_W-1:0] col_new [3];
  logic [PIX_W-1:0] nbr [8];
  logic [PIX_W-1:0] centre;
  logic [7:0]       code;
  logic             slot;
  logic             border;
  logic             emit_ok;

  assign rd_accept = (state_q == ST_RUN) && gray_ready;
  assign gray_req  = rd_accept;
  assign gray_addr = k_q;

  // Row r holds pixel k-IMG_W; row r-1 is fed from row r's output, giving k-2*IMG_W
  lbp_line_buf #(
    .DEPTH (IMG_W),
    .WIDTH (PIX_W)
  ) u_lb_mid (
    .clk      (clk),
    .reset    (reset),
    .shift_en (rd_accept),
    .wr_data  (gray_data),
    .rd_data  (mid_new)
  );

  lbp_line_buf #(
    .DEPTH (IMG_W),
    .WIDTH (PIX_W)
  ) u_lb_top (
    .clk      (clk),
    .reset    (reset),
    .shift_en (rd_accept),
    .wr_data  (mid_new),
    .rd_data  (top_new)
  );

  assign col_new[0] = top_new;
  assign col_new[1] = mid_new;
  assign col_new[2] = gray_data;

  // The incoming column is the right edge of the window, so the code is formed
  // in the same cycle as the read that completes it.
  assign nbr[B_TL] = win_q[0][0];
  assign nbr[B_T]  = win_q[0][1];
  assign nbr[B_TR] = col_new[0];
  assign nbr[B_L]  = win_q[1][0];
  assign nbr[B_R]  = col_new[1];
  assign nbr[B_BL] = win_q[2][0];
  assign nbr[B_B]  = win_q[2][1];
  assign nbr[B_BR] = col_new[2];
  assign centre    = win_q[1][1];

  generate
    for (genvar i = 0; i < 8; i++) begin : g_cmp
      assign code[i] = ({1'b0, nbr[i]} >= ({1'b0, centre} + THR_EXT));
    end
  endgenerate

  assign slot    = (rd_accept && (k_q >= K_FIRST_OUT)) || (state_q == ST_FLUSH);
  assign border  = (cen_row_q == '0) || (cen_row_q == ROW_LAST) ||
                   (cen_col_q == '0) || (cen_col_q == COL_LAST);
  assign emit_ok = (WRITE_BORDER != 0) || !border;

  always_comb begin
    win_d = win_q;
    if (rd_accept) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = col_new[r];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    fl_d        = fl_q;
    cen_addr_d  = cen_addr_q;
    cen_col_d   = cen_col_q;
    cen_row_d   = cen_row_q;
    lbp_valid_d = 1'b0;
    lbp_addr_d  = lbp_addr_q;
    lbp_data_d  = lbp_data_q;
    finish_d    = finish_q;

    case (state_q)
      ST_IDLE: begin
        if (gray_ready) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (rd_accept) begin
          if (k_q == K_LAST) state_d = ST_FLUSH;
          else               k_d     = k_q + ADDR_W'(1);
        end
      end
      ST_FLUSH: begin
        fl_d = fl_q + FL_W'(1);
        if (fl_q == FL_LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        finish_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Every slot consumes one centre, whether or not it is written
    if (slot) begin
      lbp_valid_d = emit_ok;
      lbp_addr_d  = cen_addr_q;
      lbp_data_d  = border ? 8'h00 : code;
      cen_addr_d  = cen_addr_q + ADDR_W'(1);
      if (cen_col_q == COL_LAST) begin
        cen_col_d = '0;
        cen_row_d = cen_row_q + ROW_W'(1);
      end else begin
        cen_col_d = cen_col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      fl_q        <= '0;
      cen_addr_q  <= '0;
      cen_col_q   <= '0;
      cen_row_q   <= '0;
      lbp_valid_q <= 1'b0;
      lbp_addr_q  <= '0;
      lbp_data_q  <= '0;
      finish_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      fl_q        <= fl_d;
      cen_addr_q  <= cen_addr_d;
      cen_col_q   <= cen_col_d;
      cen_row_q   <= cen_row_d;
      lbp_valid_q <= lbp_valid_d;
      lbp_addr_q  <= lbp_addr_d;
      lbp_data_q  <= lbp_data_d;
      finish_q    <= finish_d;
    end
  end

  always_ff @(posedge clk) begin
    win_q <= win_d;
  end

  assign lbp_valid = lbp_valid_q;
  assign lbp_addr  = lbp_addr_q;
  assign lbp_data  = lbp_data_q;
  assign finish    = finish_q;

endmodule
`default_nettype wire
